sysid_ext: RTL
==============

# sysid_ext

Parametrised system-identification slave for the Avalon-MM control bus. It returns a fixed system ID and build timestamp, plus a capability word and a self-computed checksum over the identity words. It also provides writable scratch registers and an optional 64-bit uptime counter, so software can probe bus health and measure elapsed time. It sits on the control slave port next to the other peripheral slaves and runs entirely from the system clock.

## Interface
Parameters:
- SYSTEM_ID, 32'd12345678: value returned at word 0.
- TIMESTAMP, 32'd1432136928: build timestamp returned at word 1.
- SCRATCH_WORDS, 2: number of read/write scratch words, 1..(2**ADDR_W − 8).
- ADDR_W, 4: word-address width.
- VERSION, 16'h0002: block version reported in CAPS[31:16].

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.
- waitrequest  out  1  stall; the request is held until low.

## Operation
Register map (word address):
- 0 ID: SYSTEM_ID, read-only.
- 1 TS: TIMESTAMP, read-only.
- 2 CAPS: [31:16] VERSION, [8] uptime present, [7:0] SCRATCH_WORDS, other bits 0.
- 3 STATUS: [0] checksum_done, other bits 0.
- 4 UPTIME_LO: low 32 bits of the uptime counter. A read also copies the high 32 bits into the shadow register.
- 5 UPTIME_HI: shadow register.
- 6 CHECKSUM: result of the checksum FSM.
- 7 CONTROL: a write with writedata[0]=1 clears the uptime counter and shadow. Reads return 0.
- 8..8+SCRATCH_WORDS−1: scratch words, read/write.
- Writes to read-only or unmapped addresses are ignored. Reads of unmapped addresses return 0.

Checksum FSM:
- States: CALC_ID → CALC_TS → CALC_CAPS → DONE, one word per cycle.
- The accumulator c starts at 0. Each step computes c ← {c[30:0],c[31]} ^ word.
- DONE is held until reset. checksum_done=1 only in DONE.

Uptime counter:
- 64-bit, increments by 1 every clock, wraps from 2^64−1 to 0.

## Timing
- Reset values:
  - readdata=0, readdatavalid=0, checksum_done=0.
  - Scratch words, uptime counter, shadow and checksum accumulator all 0.
  - FSM in CALC_ID.
- waitrequest is combinational. It is 1 only when read=1, address=6 and the FSM is not in DONE; otherwise it is 0. Writes never stall.
- Read accept: read=1 and waitrequest=0 at edge T. readdata is updated at T and readdatavalid=1 for the cycle after T, then 0. Back-to-back reads give back-to-back valids.
- After reset deasserts, the FSM reaches DONE at the third edge. A CHECKSUM read stalls at most 3 cycles.
- Write: takes effect at the accepting edge and is visible to a read accepted on the next edge.
- UPTIME_LO read at edge T returns the counter value before that edge's increment. The shadow captures the high half of that same 64-bit value, so lo/hi are coherent.
- CONTROL clear at edge T: the counter is 0 after T and then increments normally. A UPTIME_LO read in the same cycle returns the pre-clear value, and the shadow captures the pre-clear high half; the clear then overrides the shadow to 0.
- Simultaneous read and write: both are performed. The read returns the old value.
- Reset asserted mid-checksum or mid-read: all state returns to reset values immediately, and a pending readdatavalid is dropped. The FSM restarts from CALC_ID.

## Configuration
- SYSID_UPTIME_EN defined:
  - Uptime counter, shadow and CONTROL clear are present.
  - CAPS[8]=1.
- SYSID_UPTIME_EN undefined:
  - No counter or shadow logic is built.
  - Words 4, 5 and 7 read 0; writes to word 7 are ignored.
  - CAPS[8]=0.
  - The checksum uses the resulting CAPS value.

## Test plan
All scenarios use default parameters with SYSID_UPTIME_EN defined.
- ID/TS/CAPS: read words 0, 1, 2 → 0x00BC614E, 0x555CACE0, 0x00020102, each with readdatavalid one cycle after accept.
- Checksum stall: read word 6 on the first cycle after reset release → waitrequest high until the FSM reaches DONE, then 0xA84ADDFA; STATUS read afterwards = 0x1.
- Scratch: write 0xDEADBEEF to word 8 and 0x12345678 to word 9, read both back → same values; read word 10 → 0; write word 0 then read it → still 0x00BC614E.
- Uptime coherence: force the counter to 0x00000000_FFFFFFFF, read LO then HI → 0xFFFFFFFF then 0x00000000, with no torn value.
- Clear: write 1 to word 7, then read LO 3 cycles later → small value (2 or 3 per the timing rules), HI=0.
- Reset mid-stream: assert reset during an accepted read → readdatavalid stays 0, all registers return to reset values, and the checksum recomputes to 0xA84ADDFA.

Source files
------------

// File: rtl/sysid_ext.sv
// sysid_ext -- system-identification slave on the Avalon-MM control bus.
//
// Returns a fixed system ID, build timestamp, capability word and a checksum
// over those three identity words (computed once after reset by a small FSM).
// Also provides read/write scratch words and, optionally, a free-running
// 64-bit uptime counter with a coherent high-half shadow.
//
// Build option: define SYSID_UPTIME_EN to include the uptime counter, its
// shadow register and the CONTROL clear. Without it, words 4, 5 and 7 read 0
// and CAPS[8] is 0.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   address        in   word address (ADDR_W bits)
//   read           in   read request
//   write          in   write request
//   writedata      in   32-bit write data
//   readdata       out  registered read data
//   readdatavalid  out  one-cycle pulse qualifying readdata
//   waitrequest    out  stall (only for CHECKSUM reads before the FSM is done)
module sysid_ext #(
    parameter logic [31:0] SYSTEM_ID     = 32'd12345678,
    parameter logic [31:0] TIMESTAMP     = 32'd1432136928,
    parameter int          SCRATCH_WORDS = 2,
    parameter int          ADDR_W        = 4,
    parameter logic [15:0] VERSION       = 16'h0002
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic              waitrequest
);

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam logic [31:0] CAPS_WORD =
        {VERSION, 7'd0, UPTIME_PRESENT, 8'(SCRATCH_WORDS)};

    typedef enum logic [1:0] {
        CALC_ID,
        CALC_TS,
        CALC_CAPS,
        DONE
    } cks_state_t;

    cks_state_t  state_q;
    logic [31:0] cks_q;
    logic        cks_done_q;
    logic [31:0] scratch_q [SCRATCH_WORDS];
    logic [31:0] readdata_q;
    logic        rdv_q;
    logic [31:0] rdata_d;
    logic        rd_acc;

    function automatic logic [31:0] rotl1(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    // Only a CHECKSUM read can stall, and only until the FSM has finished.
    assign waitrequest = read && (address == ADDR_W'(6)) && (state_q != DONE);
    assign rd_acc      = read && !waitrequest;

    // Checksum FSM: rotate-left-by-one then XOR, one identity word per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= CALC_ID;
            cks_q      <= '0;
            cks_done_q <= 1'b0;
        end else begin
            case (state_q)
                CALC_ID: begin
                    cks_q   <= rotl1(cks_q) ^ SYSTEM_ID;
                    state_q <= CALC_TS;
                end
                CALC_TS: begin
                    cks_q   <= rotl1(cks_q) ^ TIMESTAMP;
                    state_q <= CALC_CAPS;
                end
                CALC_CAPS: begin
                    cks_q      <= rotl1(cks_q) ^ CAPS_WORD;
                    cks_done_q <= 1'b1;
                    state_q    <= DONE;
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime_q;
    logic [31:0] shadow_q;
    logic        clear_d;
    logic        lo_rd_d;

    assign clear_d = write && (address == ADDR_W'(7)) && writedata[0];
    assign lo_rd_d = rd_acc && (address == ADDR_W'(4));

    // The shadow grabs the high half of the same pre-increment value the
    // LO read returns; a same-cycle clear wins over the capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uptime_q <= '0;
            shadow_q <= '0;
        end else begin
            uptime_q <= clear_d ? 64'd0 : uptime_q + 64'd1;
            if (clear_d)
                shadow_q <= '0;
            else if (lo_rd_d)
                shadow_q <= uptime_q[63:32];
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SCRATCH_WORDS; i++)
                scratch_q[i] <= '0;
        end else begin
            for (int i = 0; i < SCRATCH_WORDS; i++)
                if (write && (address == ADDR_W'(8 + i)))
                    scratch_q[i] <= writedata;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_W'(0): rdata_d = SYSTEM_ID;
            ADDR_W'(1): rdata_d = TIMESTAMP;
            ADDR_W'(2): rdata_d = CAPS_WORD;
            ADDR_W'(3): rdata_d = {31'd0, cks_done_q};
`ifdef SYSID_UPTIME_EN
            ADDR_W'(4): rdata_d = uptime_q[31:0];
            ADDR_W'(5): rdata_d = shadow_q;
`endif
            ADDR_W'(6): rdata_d = cks_q;
            default:    rdata_d = '0;
        endcase
        for (int i = 0; i < SCRATCH_WORDS; i++)
            if (address == ADDR_W'(8 + i))
                rdata_d = scratch_q[i];
    end

    // Read data is captured from pre-edge state, so a simultaneous write
    // to the same word returns the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            rdv_q <= rd_acc;
            if (rd_acc)
                readdata_q <= rdata_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule
